// File: rtl/bus_pkg.sv
// Shared bus types and constants for the coherence bus and its L2 port.
package bus_pkg;

    localparam int unsigned BLOCK_SIZE = 1;
    localparam int unsigned DATA_WIDTH = 32 * BLOCK_SIZE;
    localparam int unsigned ADDR_WIDTH = 32;
    localparam int unsigned BYTE_OFF_W = $clog2(DATA_WIDTH / 8);

    typedef logic [DATA_WIDTH-1:0] bus_word_t;
    typedef logic [ADDR_WIDTH-1:0] bus_addr_t;

    typedef enum logic [1:0] {
        L2_FREE   = 2'd0,
        L2_BUSY   = 2'd1,
        L2_ACCESS = 2'd2,
        L2_ERROR  = 2'd3
    } l2_state_t;

    typedef enum logic [0:0] {
        XFER_WORD  = 1'b0,
        XFER_BLOCK = 1'b1
    } transfer_width_t;

    typedef enum logic [0:0] {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } l2_op_t;

    // Address must be word-aligned and have no bits above the word index.
    function automatic logic l2_addr_ok(input bus_addr_t addr, input int unsigned idx_w);
        bus_addr_t mask;
        mask = bus_addr_t'(DATA_WIDTH / 8 - 1);
        return ((addr & mask) == '0) && ((addr >> (BYTE_OFF_W + idx_w)) == '0);
    endfunction

endpackage

// File: rtl/l2_responder_if.sv
// L2 port between the bus controller (master) and the L2 responder (slave).
interface l2_responder_if;
    import bus_pkg::*;

    logic      l2REN;
    logic      l2WEN;
    bus_addr_t l2addr;
    bus_word_t l2store;
    bus_word_t l2load;
    l2_state_t l2state;

    modport master (
        output l2REN, l2WEN, l2addr, l2store,
        input  l2load, l2state
    );

    modport slave (
        input  l2REN, l2WEN, l2addr, l2store,
        output l2load, l2state
    );

endinterface

// File: rtl/l2_mem_array.sv
// Single-port synchronous RAM: one read or write per cycle, registered read data.
module l2_mem_array
    import bus_pkg::*;
#(
    parameter int unsigned WORDS = 1024
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     rd_en_i,
    input  logic                     wr_en_i,
    input  logic [$clog2(WORDS)-1:0] idx_i,
    input  bus_word_t                wdata_i,
    output bus_word_t                rdata_o
);

    bus_word_t mem [WORDS];
    bus_word_t rdata_q;

    // Storage array: never reset, contents survive a responder reset.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem[idx_i] <= wdata_i;
        end
    end

    // Read register: only updated by a read, so it holds the last read value.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (rd_en_i && !wr_en_i) begin
            rdata_q <= mem[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/l2_responder.sv
// Fixed-latency L2 responder: request checks, latency counter and abort detection
// around a single-port backing RAM.
module l2_responder
    import bus_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 1024,
    parameter int unsigned LATENCY   = 4
) (
    input logic           clk,
    input logic           RST,
    l2_responder_if.slave l2_if
);

    localparam int unsigned IdxW = $clog2(MEM_WORDS);
    localparam int unsigned CntW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    l2_state_t       state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    l2_op_t          op_q, op_d;
    bus_addr_t       addr_q, addr_d;

    logic            req_any;
    logic            req_both;
    logic            addr_ok;
    logic            req_match;
    l2_op_t          req_op;
    logic            rd_en;
    logic            wr_en;
    logic [IdxW-1:0] ram_idx;

    // Decode the incoming request and compare it with the captured one.
    always_comb begin
        req_any   = l2_if.l2REN | l2_if.l2WEN;
        req_both  = l2_if.l2REN & l2_if.l2WEN;
        req_op    = l2_if.l2WEN ? OP_WRITE : OP_READ;
        addr_ok   = l2_addr_ok(l2_if.l2addr, IdxW);
        req_match = req_any && !req_both && (req_op == op_q) && (l2_if.l2addr == addr_q);
    end

    // State register.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_q <= L2_FREE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; any change to the held request while BUSY aborts.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            L2_FREE: begin
                if (req_both || (req_any && !addr_ok)) begin
                    state_d = L2_ERROR;
                end else if (req_any) begin
                    state_d = (LATENCY == 1) ? L2_ACCESS : L2_BUSY;
                end
            end
            L2_BUSY: begin
                if (!req_match) begin
                    state_d = L2_FREE;
                end else if (cnt_q == CntW'(1)) begin
                    state_d = L2_ACCESS;
                end
            end
            L2_ACCESS: state_d = L2_FREE;
            L2_ERROR:  state_d = L2_FREE;
            default:   state_d = L2_FREE;
        endcase
    end

    // Counter and captured request registers.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            cnt_q  <= '0;
            op_q   <= OP_READ;
            addr_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            op_q   <= op_d;
            addr_q <= addr_d;
        end
    end

    // Capture on acceptance from FREE, count down while BUSY.
    always_comb begin
        cnt_d  = cnt_q;
        op_d   = op_q;
        addr_d = addr_q;
        if ((state_q == L2_FREE) && ((state_d == L2_BUSY) || (state_d == L2_ACCESS))) begin
            op_d   = req_op;
            addr_d = l2_if.l2addr;
            cnt_d  = CntW'(LATENCY - 1);
        end else if (state_q == L2_BUSY) begin
            cnt_d = cnt_q - CntW'(1);
        end
    end

    // Outputs: read issued on the edge into ACCESS, write committed at the end of ACCESS.
    always_comb begin
        l2_if.l2state = state_q;
        wr_en         = (state_q == L2_ACCESS) && (op_q == OP_WRITE);
        rd_en         = (state_d == L2_ACCESS) &&
                        (((state_q == L2_FREE) && (req_op == OP_READ)) ||
                         ((state_q == L2_BUSY) && (op_q == OP_READ)));
        // From FREE (single-cycle latency) the address has not been captured yet.
        if (state_q == L2_FREE) begin
            ram_idx = l2_if.l2addr[BYTE_OFF_W +: IdxW];
        end else begin
            ram_idx = addr_q[BYTE_OFF_W +: IdxW];
        end
    end

    l2_mem_array #(
        .WORDS (MEM_WORDS)
    ) u_mem (
        .clk_i   (clk),
        .rst_i   (RST),
        .rd_en_i (rd_en),
        .wr_en_i (wr_en),
        .idx_i   (ram_idx),
        .wdata_i (l2_if.l2store),
        .rdata_o (l2_if.l2load)
    );

endmodule

// File: tb/tb_l2_responder.sv
// Bench for l2_responder: two instances (LATENCY 4 and 1) against a word-array model.
module tb_l2_responder;
    import bus_pkg::*;

    localparam int unsigned MW = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    l2_responder_if b4 ();
    l2_responder_if b1 ();

    l2_responder #(.MEM_WORDS(MW), .LATENCY(4)) dut4 (
        .clk   (clk),
        .RST   (rst),
        .l2_if (b4.slave)
    );

    l2_responder #(.MEM_WORDS(MW), .LATENCY(1)) dut1 (
        .clk   (clk),
        .RST   (rst),
        .l2_if (b1.slave)
    );

    int total = 0;
    int bad   = 0;

    bus_word_t ref_mem [2][MW];
    bus_word_t ref_load [2];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int sel, input logic r, input logic w,
                         input bus_addr_t a, input bus_word_t d);
        if (sel == 0) begin
            b4.l2REN = r; b4.l2WEN = w; b4.l2addr = a; b4.l2store = d;
        end else begin
            b1.l2REN = r; b1.l2WEN = w; b1.l2addr = a; b1.l2store = d;
        end
    endtask

    function automatic l2_state_t get_st(input int sel);
        return (sel == 0) ? b4.l2state : b1.l2state;
    endfunction

    function automatic bus_word_t get_ld(input int sel);
        return (sel == 0) ? b4.l2load : b1.l2load;
    endfunction

    task automatic chk_st(input int sel, input l2_state_t exp, input string tag);
        l2_state_t got;
        got = get_st(sel);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s dut%0d l2state: got %0d expected %0d", tag, sel, got, exp);
        end
    endtask

    task automatic chk_ld(input int sel, input bus_word_t exp, input string tag);
        bus_word_t got;
        got = get_ld(sel);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s dut%0d l2load: got %h expected %h", tag, sel, got, exp);
        end
    endtask

    function automatic bit legal(input bus_addr_t a);
        return (a % 4 == 0) && (a < 4 * MW);
    endfunction

    // One complete transaction; with hold the request stays asserted past ACCESS.
    task automatic txn(input int sel, input logic r, input logic w, input bus_addr_t a,
                       input bus_word_t d, input bit hold, input string tag);
        int lat;
        lat = (sel == 0) ? 4 : 1;
        drive(sel, r, w, a, d);
        tick();
        if ((r && w) || !legal(a)) begin
            chk_st(sel, L2_ERROR, tag);
            chk_ld(sel, ref_load[sel], tag);
            drive(sel, 1'b0, 1'b0, a, d);
            tick();
            chk_st(sel, L2_FREE, tag);
            chk_ld(sel, ref_load[sel], tag);
        end else begin
            for (int i = 1; i < lat; i++) begin
                chk_st(sel, L2_BUSY, tag);
                tick();
            end
            chk_st(sel, L2_ACCESS, tag);
            if (r) begin
                ref_load[sel] = ref_mem[sel][a / 4];
            end else begin
                ref_mem[sel][a / 4] = d;
            end
            chk_ld(sel, ref_load[sel], tag);
            if (!hold) begin
                drive(sel, 1'b0, 1'b0, a, d);
            end
            tick();
            chk_st(sel, L2_FREE, tag);
            chk_ld(sel, ref_load[sel], tag);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_word_t v;
        bus_addr_t a;
        bus_word_t d;
        logic      r, w;
        int        k, m;

        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < int'(MW); i++) begin
            v = $urandom;
            dut4.u_mem.mem[i] = v;
            ref_mem[0][i] = v;
            v = $urandom;
            dut1.u_mem.mem[i] = v;
            ref_mem[1][i] = v;
        end
        ref_load[0] = '0;
        ref_load[1] = '0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        chk_st(0, L2_FREE, "reset");
        chk_ld(0, '0, "reset");
        chk_st(1, L2_FREE, "reset");
        chk_ld(1, '0, "reset");

        // Write then read back.
        txn(0, 1'b0, 1'b1, 32'h40, 32'hDEADBEEF, 1'b0, "wr40");
        txn(0, 1'b1, 1'b0, 32'h40, '0, 1'b0, "rd40");

        // Error cases leave memory and l2load alone.
        txn(0, 1'b1, 1'b1, 32'h40, 32'h0BAD0BAD, 1'b0, "err_both");
        txn(0, 1'b1, 1'b0, 32'h42, '0, 1'b0, "err_misalign");
        txn(0, 1'b1, 1'b0, 4 * MW, '0, 1'b0, "err_range");
        txn(0, 1'b0, 1'b1, 32'h42, 32'h11111111, 1'b0, "err_wr_misalign");
        txn(0, 1'b1, 1'b0, 32'h40, '0, 1'b0, "rd40_after_err");

        // Abort by dropping the request after two BUSY cycles.
        drive(0, 1'b0, 1'b1, 32'h80, 32'h12345678);
        tick();
        chk_st(0, L2_BUSY, "abort_drop");
        tick();
        chk_st(0, L2_BUSY, "abort_drop");
        drive(0, 1'b0, 1'b0, 32'h80, 32'h12345678);
        tick();
        chk_st(0, L2_FREE, "abort_drop");
        txn(0, 1'b1, 1'b0, 32'h80, '0, 1'b0, "rd80_after_abort");

        // Abort by changing the address mid-BUSY.
        drive(0, 1'b0, 1'b1, 32'hC0, 32'h55AA55AA);
        tick();
        chk_st(0, L2_BUSY, "abort_addr");
        drive(0, 1'b0, 1'b1, 32'hC4, 32'h55AA55AA);
        tick();
        chk_st(0, L2_FREE, "abort_addr");
        drive(0, 1'b0, 1'b0, 32'hC4, 32'h55AA55AA);
        tick();
        txn(0, 1'b1, 1'b0, 32'hC0, '0, 1'b0, "rdC0_after_abort");
        txn(0, 1'b1, 1'b0, 32'hC4, '0, 1'b0, "rdC4_after_abort");

        // Single-cycle latency instance.
        txn(1, 1'b1, 1'b0, 32'h10, '0, 1'b0, "lat1_rd10");
        txn(1, 1'b0, 1'b1, 32'h10, 32'hA5A5F00D, 1'b0, "lat1_wr10");
        txn(1, 1'b1, 1'b0, 32'h10, '0, 1'b0, "lat1_rd10b");

        // Request held across ACCESS starts a fresh transaction after one FREE cycle.
        txn(0, 1'b1, 1'b0, 32'h40, '0, 1'b1, "held_first");
        txn(0, 1'b1, 1'b0, 32'h40, '0, 1'b0, "held_second");

        // Reset in the middle of a write.
        txn(0, 1'b1, 1'b0, 32'h200, '0, 1'b0, "rd200_pre");
        drive(0, 1'b0, 1'b1, 32'h200, 32'hCAFEF00D);
        tick();
        chk_st(0, L2_BUSY, "rst_mid");
        tick();
        chk_st(0, L2_BUSY, "rst_mid");
        rst = 1'b1;
        #1;
        ref_load[0] = '0;
        ref_load[1] = '0;
        chk_st(0, L2_FREE, "rst_mid");
        chk_ld(0, '0, "rst_mid");
        chk_ld(1, '0, "rst_mid");
        drive(0, 1'b0, 1'b0, 32'h200, 32'hCAFEF00D);
        tick();
        rst = 1'b0;
        tick();
        txn(0, 1'b1, 1'b0, 32'h200, '0, 1'b0, "rd200_post_rst");

        // Random mix on both instances over a small address window.
        for (int sel = 0; sel < 2; sel++) begin
            for (int n = 0; n < 40; n++) begin
                k = $urandom_range(0, 15);
                r = (k < 8) || (k == 15);
                w = (k >= 8);
                m = $urandom_range(0, 9);
                if (m == 0) begin
                    a = bus_addr_t'($urandom_range(0, 31) * 4 + $urandom_range(1, 3));
                end else if (m == 1) begin
                    a = bus_addr_t'(4 * MW + 4 * $urandom_range(0, 100));
                end else begin
                    a = bus_addr_t'($urandom_range(0, 31) * 4);
                end
                d = $urandom;
                txn(sel, r, w, a, d, 1'b0, "random");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
